// File: rtl/product_serializer_pkg.sv
// Shared defaults and state encoding for the product serializer.
package product_serializer_pkg;

   localparam int DEF_RESULT_W = 256;
   localparam int DEF_BYTE_W   = 8;
   localparam int NBYTES       = DEF_RESULT_W / DEF_BYTE_W;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

endpackage

// File: rtl/product_serializer_sign_trunc_check.sv
// Flags when truncating a signed product to K = BYTE_W*(len_m1+1) bits
// would lose information, i.e. the dropped upper bits are not copies of
// the new sign bit K-1.
module sign_trunc_check
   import product_serializer_pkg::*;
#(
   parameter int RESULT_W = DEF_RESULT_W,
   parameter int BYTE_W   = DEF_BYTE_W
) (
   input  logic [RESULT_W-1:0] data,
   input  logic [4:0]          len_m1,
   output logic                ovf
);

   int   k;
   logic sign_bit;

   // Pick the sign bit of the kept field, then compare every discarded bit to it.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      ovf      = 1'b0;
      sign_bit = 1'b0;
      k        = (int'(len_m1) + 1) * BYTE_W;
      for (int i = 0; i < RESULT_W; i++) begin
         if (i == k - 1) sign_bit = data[i];
      end
      // A field covering the whole product discards nothing, so ovf stays 0.
      for (int i = 0; i < RESULT_W; i++) begin
         if (i >= k && data[i] != sign_bit) ovf = 1'b1;
      end
   end

endmodule

// File: rtl/product_serializer.sv
// Accepts a wide signed product and streams its low len_m1+1 bytes
// least-significant first over a valid/ready byte interface.
module product_serializer
   import product_serializer_pkg::*;
#(
   parameter int RESULT_W = DEF_RESULT_W,
   parameter int BYTE_W   = DEF_BYTE_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                prod_valid,
   output logic                prod_ready,
   input  logic [RESULT_W-1:0] prod_data,
   input  logic [4:0]          len_m1,
   output logic                byte_valid,
   input  logic                byte_ready,
   output logic [BYTE_W-1:0]   byte_data,
   output logic                byte_last,
   output logic                trunc_ovf
);

   state_e              state_q, state_d;
   logic [RESULT_W-1:0] sreg_q, sreg_d;
   logic [4:0]          cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                ovf_w;

   sign_trunc_check #(
      .RESULT_W (RESULT_W),
      .BYTE_W   (BYTE_W)
   ) u_sign_trunc_check (
      .data   (prod_data),
      .len_m1 (len_m1),
      .ovf    (ovf_w)
   );

   // Next-state: capture in IDLE, shift/count down on each byte handshake in SEND.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (prod_valid) begin
               sreg_d  = prod_data;
               cnt_d   = len_m1;
               ovf_d   = ovf_w;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            // prod_valid is deliberately ignored here; nothing is captured mid-transfer.
            if (byte_ready) begin
               if (cnt_q == 5'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  sreg_d = sreg_q >> BYTE_W;
                  cnt_d  = cnt_q - 5'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q <= ST_IDLE;
         // NOTE: the shift register is ordinary flops, not a memory, so it is cleared on reset.
         sreg_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Outputs decode directly from registered state, so they hold while stalled.
   always_comb begin
      prod_ready = (state_q == ST_IDLE);
      byte_valid = (state_q == ST_SEND);
      byte_data  = (state_q == ST_SEND) ? sreg_q[BYTE_W-1:0] : '0;
      byte_last  = (state_q == ST_SEND) && (cnt_q == 5'd0);
      trunc_ovf  = ovf_q;
   end

endmodule
